// File: rtl/qgemm_basic_reset_seq_pkg.sv
// qgemm_basic_reset_seq_pkg
//   Shared definitions for the qgemm_basic reset sequencer:
//   - seq_state_e : sequencer FSM states
//   - DEF_*       : default parameter values
//   - cnt_width() : counter width able to hold 0..max_val without wrapping
package qgemm_basic_reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    RUN,
    HOLD
  } seq_state_e;

  localparam int DEF_NUM_DOMAIN          = 3;
  localparam int DEF_LOCK_FILTER_CYCLES  = 16;
  localparam int DEF_RELEASE_GAP_CYCLES  = 8;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1024;

  // Width of a counter covering 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/qgemm_basic_sat_counter.sv
// qgemm_basic_sat_counter
//   Up-counter that saturates at MAX. Used for the lock timeout, lock
//   filter and release gap counters of the reset sequencer.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset (count -> 0)
//   clear   in  synchronous clear, wins over enable
//   enable  in  count one step this edge (held at MAX once there)
//   reached out high when the enabled step on this edge brings the count
//               to MAX; purely a function of enable and the current count,
//               so the owner may use it to decide clear without a loop
module qgemm_basic_sat_counter
  import qgemm_basic_reset_seq_pkg::*;
#(
  parameter int MAX = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic reached
);

  localparam int W = cnt_width(MAX);
  localparam logic [W-1:0] MAX_VAL  = W'(MAX);
  localparam logic [W-1:0] LAST_VAL = W'(MAX - 1);

  logic [W-1:0] count;

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != MAX_VAL)) begin
      count <= count + W'(1);
    end
  end

  assign reached = enable && (count == LAST_VAL);

endmodule

// File: rtl/qgemm_basic_reset_sequencer.sv
// qgemm_basic_reset_sequencer
//   Waits for a filtered PLL lock, then releases the per-domain active-low
//   resets in index order with a fixed gap. Lock loss or a software request
//   re-asserts all resets; lock timeout and lock loss raise sticky flags.
// Ports:
//   clk              in  clock
//   rst              in  synchronous active-high reset
//   pll_locked       in  PLL lock, already synchronous to clk
//   soft_reset_req   in  one-cycle request to re-run the release sequence
//   domain_rstnn     out [NUM_DOMAIN] active-low domain resets
//   seq_done         out high while all domains are released
//   lock_timeout_err out sticky: no lock within LOCK_TIMEOUT_CYCLES
//   lock_lost_err    out sticky: lock dropped during RELEASE/RUN/HOLD
// All outputs come straight from registers.
module qgemm_basic_reset_sequencer
  import qgemm_basic_reset_seq_pkg::*;
#(
  parameter int NUM_DOMAIN          = DEF_NUM_DOMAIN,
  parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int RELEASE_GAP_CYCLES  = DEF_RELEASE_GAP_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic [NUM_DOMAIN-1:0] domain_rstnn,
  output logic                  seq_done,
  output logic                  lock_timeout_err,
  output logic                  lock_lost_err
);

  localparam int IDX_W = cnt_width(NUM_DOMAIN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAIN - 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAIN-1:0]  domain_rstnn_d;
  logic                   seq_done_d;
  logic                   lock_timeout_err_d;
  logic                   lock_lost_err_d;

  logic timeout_en, timeout_clr, timeout_hit;
  logic filter_en,  filter_clr,  filter_hit;
  logic gap_en,     gap_clr,     gap_hit;

  // Consecutive low samples while waiting for lock.
  qgemm_basic_sat_counter #(.MAX(LOCK_TIMEOUT_CYCLES)) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (timeout_clr),
    .enable  (timeout_en),
    .reached (timeout_hit)
  );

  // Consecutive high samples of pll_locked before release starts.
  qgemm_basic_sat_counter #(.MAX(LOCK_FILTER_CYCLES)) u_filter_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (filter_clr),
    .enable  (filter_en),
    .reached (filter_hit)
  );

  // Spacing between release steps, and the HOLD duration after a soft reset.
  qgemm_basic_sat_counter #(.MAX(RELEASE_GAP_CYCLES)) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clr),
    .enable  (gap_en),
    .reached (gap_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= WAIT_LOCK;
      idx_q            <= '0;
      domain_rstnn     <= '0;
      seq_done         <= 1'b0;
      lock_timeout_err <= 1'b0;
      lock_lost_err    <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      domain_rstnn     <= domain_rstnn_d;
      seq_done         <= seq_done_d;
      lock_timeout_err <= lock_timeout_err_d;
      lock_lost_err    <= lock_lost_err_d;
    end
  end

  // NOTE: every signal assigned below gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    domain_rstnn_d     = domain_rstnn;
    seq_done_d         = seq_done;
    lock_timeout_err_d = lock_timeout_err;
    lock_lost_err_d    = lock_lost_err;
    // Counters idle at zero unless the current state is actively using them.
    timeout_en  = 1'b0;
    timeout_clr = 1'b1;
    filter_en   = 1'b0;
    filter_clr  = 1'b1;
    gap_en      = 1'b0;
    gap_clr     = 1'b1;

    unique case (state_q)
      WAIT_LOCK: begin
        if (pll_locked) begin
          filter_en  = 1'b1;
          filter_clr = 1'b0;
          // With a one-sample filter the first high sample already qualifies.
          if (filter_hit) begin
            filter_clr = 1'b1;
            idx_d      = '0;
            state_d    = RELEASE;
          end else begin
            state_d = FILTER;
          end
        end else begin
          timeout_en  = 1'b1;
          timeout_clr = 1'b0;
          if (timeout_hit) lock_timeout_err_d = 1'b1;
        end
      end

      FILTER: begin
        // A glitch while filtering only restarts the wait; it is not an error.
        if (!pll_locked) begin
          state_d = WAIT_LOCK;
        end else begin
          filter_en  = 1'b1;
          filter_clr = 1'b0;
          if (filter_hit) begin
            filter_clr = 1'b1;
            idx_d      = '0;
            state_d    = RELEASE;
          end
        end
      end

      RELEASE: begin
        if (!pll_locked) begin
          domain_rstnn_d  = '0;
          seq_done_d      = 1'b0;
          lock_lost_err_d = 1'b1;
          state_d         = WAIT_LOCK;
        end else begin
          gap_en  = 1'b1;
          gap_clr = 1'b0;
          if (gap_hit) begin
            gap_clr               = 1'b1;
            domain_rstnn_d[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
              seq_done_d = 1'b1;
              state_d    = RUN;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      RUN: begin
        // Lock loss takes priority over a coincident soft reset request.
        if (!pll_locked) begin
          domain_rstnn_d  = '0;
          seq_done_d      = 1'b0;
          lock_lost_err_d = 1'b1;
          state_d         = WAIT_LOCK;
        end else if (soft_reset_req) begin
          domain_rstnn_d = '0;
          seq_done_d     = 1'b0;
          state_d        = HOLD;
        end
      end

      HOLD: begin
        if (!pll_locked) begin
          domain_rstnn_d  = '0;
          seq_done_d      = 1'b0;
          lock_lost_err_d = 1'b1;
          state_d         = WAIT_LOCK;
        end else begin
          gap_en  = 1'b1;
          gap_clr = 1'b0;
          // Lock is already known good here, so go straight to release.
          if (gap_hit) begin
            gap_clr = 1'b1;
            idx_d   = '0;
            state_d = RELEASE;
          end
        end
      end

      default: begin
        domain_rstnn_d = '0;
        seq_done_d     = 1'b0;
        state_d        = WAIT_LOCK;
      end
    endcase
  end

endmodule

// File: tb/tb_qgemm_basic_reset_sequencer.sv
// Testbench for qgemm_basic_reset_sequencer (default parameters).
// The reference model tracks the edge at which the release sequence is
// anchored and derives every output from the timing rules:
// domain k is released from edge base+(k+1)*G onward.
module tb_qgemm_basic_reset_sequencer;

  localparam int N = 3;
  localparam int F = 16;
  localparam int G = 8;
  localparam int T = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pll_locked = 1'b0;
  logic         soft_reset_req = 1'b0;
  logic [N-1:0] domain_rstnn;
  logic         seq_done;
  logic         lock_timeout_err;
  logic         lock_lost_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qgemm_basic_reset_sequencer #(
    .NUM_DOMAIN          (N),
    .LOCK_FILTER_CYCLES  (F),
    .RELEASE_GAP_CYCLES  (G),
    .LOCK_TIMEOUT_CYCLES (T)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pll_locked       (pll_locked),
    .soft_reset_req   (soft_reset_req),
    .domain_rstnn     (domain_rstnn),
    .seq_done         (seq_done),
    .lock_timeout_err (lock_timeout_err),
    .lock_lost_err    (lock_lost_err)
  );

  // ---------------- reference model ----------------
  int           cyc      = 0;   // global edge counter
  int           t0       = 0;   // edge of the most recent reset sample
  int           seq_base = -1;  // anchor edge of the active release sequence
  int           high_run = 0;   // consecutive high samples while unlocked
  int           low_run  = 0;   // consecutive low samples while waiting
  bit           m_to     = 1'b0;
  bit           m_ll     = 1'b0;
  logic [N-1:0] exp_rstn = '0;
  logic         exp_done = 1'b0;

  function automatic int rel_edge(input int base, input int k);
    return base + (k + 1) * G;
  endfunction

  task automatic model_edge(input bit p, input bit s, input bit r);
    if (r) begin
      seq_base = -1;
      high_run = 0;
      low_run  = 0;
      m_to     = 1'b0;
      m_ll     = 1'b0;
    end else if (seq_base >= 0) begin
      if (!p) begin
        seq_base = -1;
        high_run = 0;
        low_run  = 0;
        m_ll     = 1'b1;
      end else if (s && (cyc - 1 >= rel_edge(seq_base, N - 1))) begin
        // all domains were out before this edge: restart, first release 2G later
        seq_base = cyc + G;
      end
    end else if (p) begin
      high_run++;
      low_run = 0;
      if (high_run == F) begin
        seq_base = cyc;
        high_run = 0;
      end
    end else begin
      if (high_run > 0) low_run = 0;
      else if (low_run < T) low_run++;
      high_run = 0;
      if (low_run >= T) m_to = 1'b1;
    end
    exp_done = (seq_base >= 0);
    for (int k = 0; k < N; k++) begin
      exp_rstn[k] = (seq_base >= 0) && (cyc >= rel_edge(seq_base, k));
      exp_done    = exp_done && exp_rstn[k];
    end
  endtask

  function automatic logic [N+2:0] got();
    return {domain_rstnn, seq_done, lock_timeout_err, lock_lost_err};
  endfunction

  function automatic logic [N+2:0] want();
    return {exp_rstn, exp_done, m_to, m_ll};
  endfunction

  // Drive one edge's worth of inputs, advance the model, sample 1 time unit later.
  task automatic tick(input bit p, input bit s, input bit r);
    @(negedge clk);
    pll_locked     = p;
    soft_reset_req = s;
    rst            = r;
    @(posedge clk);
    cyc++;
    model_edge(p, s, r);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b1);
    t0 = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // outputs are unknown until the first reset edge; then all must be zero
    do_reset();
    tick(1'b1, 1'b1, 1'b1);
    checks++;
    if (got() !== '0) begin
      errors++;
      $display("FAIL reset_values: observed %b required %b", got(), {(N+3){1'b0}});
    end
    checks++;
    if (got() !== want()) begin
      errors++;
      $display("FAIL reset_model: observed %b required %b", got(), want());
    end
  endtask

  task automatic test_nominal();
    logic [N-1:0] req;
    do_reset();
    for (int n = 1; n <= 55; n++) begin
      tick(n >= 10, 1'b0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL nominal edge %0d: observed %b required %b", n, got(), want());
      end
      if (n == 32 || n == 33 || n == 41 || n == 49) begin
        req = {n >= 49, n >= 41, n >= 33};
        checks++;
        if (domain_rstnn !== req || seq_done !== (n >= 49)) begin
          errors++;
          $display("FAIL nominal_timing edge %0d: observed rstn=%b done=%b required rstn=%b done=%b",
                   n, domain_rstnn, seq_done, req, n >= 49);
        end
      end
    end
  endtask

  task automatic test_filter_glitch();
    do_reset();
    for (int n = 1; n <= 72; n++) begin
      tick((n >= 29 && n <= 38) || n >= 40, 1'b0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL glitch edge %0d: observed %b required %b", n, got(), want());
      end
      if (n == 62 || n == 63) begin
        checks++;
        if (domain_rstnn !== ((n == 63) ? 3'b001 : 3'b000) || lock_lost_err !== 1'b0) begin
          errors++;
          $display("FAIL glitch_release edge %0d: observed rstn=%b lost=%b", n, domain_rstnn, lock_lost_err);
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int n = 1; n <= 1030; n++) begin
      tick(1'b0, 1'b0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL timeout edge %0d: observed %b required %b", n, got(), want());
      end
      if (n == T - 1 || n == T) begin
        checks++;
        if (lock_timeout_err !== (n == T)) begin
          errors++;
          $display("FAIL timeout_flag edge %0d: observed %b required %b", n, lock_timeout_err, n == T);
        end
      end
    end
    for (int n = 0; n < F + N * G + 2; n++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL timeout_relock step %0d: observed %b required %b", n, got(), want());
      end
    end
    checks++;
    if (seq_done !== 1'b1 || lock_timeout_err !== 1'b1 || lock_lost_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after_lock: observed done=%b to=%b lost=%b required 1 1 0",
               seq_done, lock_timeout_err, lock_lost_err);
    end
  endtask

  task automatic test_soft_reset();
    logic [N-1:0] req;
    do_reset();
    for (int n = 1; n <= 55; n++) tick(1'b1, 1'b0, 1'b0);
    for (int d = 0; d <= 36; d++) begin
      tick(1'b1, d == 0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL soft edge S+%0d: observed %b required %b", d, got(), want());
      end
      if (d == 0 || d == 15 || d == 16 || d == 24 || d == 32) begin
        req = {d >= 32, d >= 24, d >= 16};
        checks++;
        if (domain_rstnn !== req || seq_done !== (d >= 32) ||
            lock_timeout_err !== 1'b0 || lock_lost_err !== 1'b0) begin
          errors++;
          $display("FAIL soft_timing S+%0d: observed rstn=%b done=%b to=%b lost=%b required rstn=%b done=%b",
                   d, domain_rstnn, seq_done, lock_timeout_err, lock_lost_err, req, d >= 32);
        end
      end
    end
  endtask

  // Starts from RUN (left by test_soft_reset); ends mid-RELEASE after domain 0.
  task automatic test_lock_loss_with_soft();
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if (domain_rstnn !== '0 || seq_done !== 1'b0 || lock_lost_err !== 1'b1) begin
      errors++;
      $display("FAIL loss_and_soft: observed rstn=%b done=%b lost=%b required 000 0 1",
               domain_rstnn, seq_done, lock_lost_err);
    end
    for (int n = 0; n < 3; n++) tick(1'b0, 1'b0, 1'b0);
    for (int n = 0; n <= F - 1 + G + 2; n++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL relock step %0d: observed %b required %b", n, got(), want());
      end
      if (n == F - 2 + G || n == F - 1 + G) begin
        checks++;
        if (domain_rstnn !== ((n == F - 1 + G) ? 3'b001 : 3'b000) || lock_lost_err !== 1'b1) begin
          errors++;
          $display("FAIL relock_timing step %0d: observed rstn=%b lost=%b", n, domain_rstnn, lock_lost_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_release();
    tick(1'b1, 1'b0, 1'b1);
    checks++;
    if (got() !== '0) begin
      errors++;
      $display("FAIL reset_mid_release: observed %b required %b", got(), {(N+3){1'b0}});
    end
    for (int n = 0; n < 5; n++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL post_reset step %0d: observed %b required %b", n, got(), want());
      end
    end
  endtask

  task automatic test_random();
    bit p, s, r;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      p = ($urandom_range(0, 99) < 97);
      s = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 999) < 2);
      tick(p, s, r);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL random cycle %0d in=%b%b%b: observed %b required %b", n, p, s, r, got(), want());
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_filter_glitch();
    test_timeout();
    test_soft_reset();
    test_lock_loss_with_soft();
    test_reset_mid_release();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
